// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: command/register layer sitting behind the 8-bit mode-0 spi
// peripheral. Each CS-framed transfer becomes one of: a burst write into the
// configuration bank, a burst read of the configuration or result bank, or a
// core start pulse. Byte 0 of every frame shifts out a status byte.
module spi_reg_bridge #(
    parameter int NREGS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 CS,
    input  logic [7:0]           rx_byte,
    input  logic                 rx_byte_ready,
    output logic [7:0]           tx_byte,
    output logic [NREGS*8-1:0]   cfg_regs,
    input  logic [NREGS*8-1:0]   result_regs,
    input  logic                 core_busy,
    input  logic                 core_done,
    output logic                 core_start
);

    localparam int AW = $clog2(NREGS);
    localparam int SW = AW + 3;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        READ,
        DROP
    } state_t;

    state_t          state;
    logic            cs_meta;
    logic            cs_sync;
    logic            rdy_prev;
    logic            byte_evt;
    logic [AW-1:0]   addr;
    logic            bank;
    logic            err;
    logic [SW-1:0]   sel;
    logic            cmd_w;
    logic            cmd_s;
    logic            cmd_b;
    logic            cmd_r;
    logic            is_start;
    logic            is_write;
    logic            is_read;

    // Bit offset of the addressed byte within a bank vector.
    assign sel = {addr, 3'b000};

    // Command byte fields and the three legal command shapes.
    assign cmd_w    = rx_byte[7];
    assign cmd_s    = rx_byte[6];
    assign cmd_b    = rx_byte[5];
    assign cmd_r    = rx_byte[4];
    assign is_start = cmd_s & ~cmd_w & ~cmd_b & ~cmd_r;
    assign is_write = cmd_w & ~cmd_s & ~cmd_b & ~cmd_r;
    assign is_read  = ~cmd_w & ~cmd_s & ~cmd_r;

    // Two-flop CS synchronizer, left unreset so that a CS already low at reset
    // release is seen immediately and the frame starts on the next cycle.
    always_ff @(posedge clk) begin
        cs_meta <= CS;
        cs_sync <= cs_meta;
    end

    // Registered rising-edge detector on rx_byte_ready; runs in every state so a
    // level left high from the previous frame never looks like a new byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_prev <= 1'b0;
            byte_evt <= 1'b0;
        end else begin
            rdy_prev <= rx_byte_ready;
            byte_evt <= rx_byte_ready & ~rdy_prev;
        end
    end

    // Frame state machine with registered tx_byte, register bank and start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            bank       <= 1'b0;
            err        <= 1'b0;
            core_start <= 1'b0;
            cfg_regs   <= '0;
            tx_byte    <= 8'h00;
        end else begin
            core_start <= 1'b0;

            case (state)
                IDLE, CMD: tx_byte <= {core_busy, core_done, 5'b00000, err};
                READ:      tx_byte <= bank ? result_regs[sel +: 8] : cfg_regs[sel +: 8];
                default:   tx_byte <= 8'h00;
            endcase

            if (cs_sync) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        state <= CMD;
                    end
                    CMD: begin
                        if (byte_evt) begin
                            err <= 1'b0;
                            if (is_start) begin
                                if (!core_busy) begin
                                    core_start <= 1'b1;
                                end else begin
                                    err <= 1'b1;
                                end
                                state <= DROP;
                            end else if (is_write) begin
                                addr  <= rx_byte[AW-1:0];
                                state <= WRITE;
                            end else if (is_read) begin
                                addr  <= rx_byte[AW-1:0];
                                bank  <= cmd_b;
                                state <= READ;
                            end else begin
                                err   <= 1'b1;
                                state <= DROP;
                            end
                        end
                    end
                    WRITE: begin
                        if (byte_evt) begin
                            cfg_regs[sel +: 8] <= rx_byte;
                            addr               <= addr + 1'b1;
                        end
                    end
                    READ: begin
                        if (byte_evt) begin
                            addr <= addr + 1'b1;
                        end
                    end
                    DROP: begin
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Testbench for spi_reg_bridge: drives CS-framed byte transfers at the spi byte
// interface and checks tx_byte, cfg_regs and core_start against a frame-level
// model of the command rules, plus literal expectations for directed frames.
module tb_spi_reg_bridge;

    localparam int NREGS = 16;
    localparam int W     = NREGS * 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           CS;
    logic [7:0]     rx_byte;
    logic           rx_byte_ready;
    logic [7:0]     tx_byte;
    logic [W-1:0]   cfg_regs;
    logic [W-1:0]   result_regs;
    logic           core_busy;
    logic           core_done;
    logic           core_start;

    // Model state: bank contents, sticky error, decoded current command.
    logic [7:0]     mCfg [NREGS];
    logic [7:0]     mRes [NREGS];
    logic           mErr;
    logic [7:0]     mCmd;
    bit             mIsStart;
    bit             mIsWrite;
    bit             mIsRead;
    int             mAddr;
    int             expStarts;
    int             startSeen;

    // Compare windows and expectations shared with the compare process.
    bit             txValid;
    bit             cfgValid;
    logic [7:0]     expTx;
    logic           prevStart;
    logic [7:0]     txLog [8];
    logic [7:0]     frameQ [$];

    int             vectors;
    int             miscompares;

    spi_reg_bridge #(.NREGS(NREGS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .CS            (CS),
        .rx_byte       (rx_byte),
        .rx_byte_ready (rx_byte_ready),
        .tx_byte       (tx_byte),
        .cfg_regs      (cfg_regs),
        .result_regs   (result_regs),
        .core_busy     (core_busy),
        .core_done     (core_done),
        .core_start    (core_start)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // Present the model's result bank to the DUT.
    always_comb begin
        result_regs = '0;
        for (int i = 0; i < NREGS; i++) begin
            result_regs[8*i +: 8] = mRes[i];
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] packCfg();
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < NREGS; i++) begin
            v[8*i +: 8] = mCfg[i];
        end
        return v;
    endfunction

    // Expected tx_byte while byte slot k of the current frame is being shifted.
    function automatic logic [7:0] slotExp(input int k);
        int idx;
        if (k == 0) begin
            return {core_busy, core_done, 5'b00000, mErr};
        end
        if (mIsRead) begin
            idx = (mAddr + k - 1) % NREGS;
            return mCmd[5] ? mRes[idx] : mCfg[idx];
        end
        return 8'h00;
    endfunction

    // Continuous checking of the DUT outputs whenever they are meaningful.
    always @(negedge clk) begin
        if (txValid) begin
            checkOutput("tx_byte", 128'(tx_byte), 128'(expTx));
        end
        if (cfgValid) begin
            checkOutput("cfg_regs", 128'(cfg_regs), packCfg());
        end
        if (core_start === 1'b1) begin
            startSeen++;
            checkOutput("start_width", 128'(prevStart), 128'(0));
        end
        prevStart = core_start;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic openWindows();
        expTx    = slotExp(0);
        txValid  = 1'b1;
        cfgValid = 1'b1;
    endtask

    task automatic closeWindows();
        txValid  = 1'b0;
        cfgValid = 1'b0;
    endtask

    // Change core status and result bank between frames (CS high).
    task automatic setEnv(input logic busy, input logic done, input bit randRes);
        closeWindows();
        core_busy = busy;
        core_done = done;
        if (randRes) begin
            for (int i = 0; i < NREGS; i++) begin
                mRes[i] = 8'($urandom);
            end
        end
        tick(3);
        openWindows();
        tick(2);
    endtask

    // One byte transfer: tx must hold steady while shifting, then ready rises.
    task automatic sendByte(input int k, input logic [7:0] b, input bit keepHigh);
        rx_byte_ready = 1'b0;
        rx_byte       = b;
        expTx         = slotExp(k);
        txValid       = 1'b1;
        cfgValid      = 1'b1;
        tick(8);
        txLog[k]      = tx_byte;
        closeWindows();
        rx_byte_ready = 1'b1;
        tick($urandom_range(1, 4));
        if (!keepHigh) begin
            rx_byte_ready = 1'b0;
        end
        tick(4);
    endtask

    // Run one frame from frameQ: nDone completed bytes, optional partial byte.
    task automatic applyStimulus(input int nDone, input bit partial, input bit skipCsLow, input bit endIt);
        if (!skipCsLow) begin
            CS = 1'b0;
            tick(6);
        end
        for (int k = 0; k < nDone; k++) begin
            sendByte(k, frameQ[k], 1'($urandom_range(0, 1)));
            if (k == 0) begin
                mCmd     = frameQ[0];
                mIsStart = mCmd[6] && !mCmd[7] && !mCmd[5] && !mCmd[4];
                mIsWrite = mCmd[7] && !mCmd[6] && !mCmd[5] && !mCmd[4];
                mIsRead  = !mCmd[7] && !mCmd[6] && !mCmd[4];
                mAddr    = int'(mCmd) % NREGS;
                mErr     = (mIsStart && core_busy) || !(mIsStart || mIsWrite || mIsRead);
                if (mIsStart && !core_busy) begin
                    expStarts++;
                end
            end else if (mIsWrite) begin
                mCfg[(mAddr + k - 1) % NREGS] = frameQ[k];
            end
        end
        if (partial) begin
            rx_byte_ready = 1'b0;
            rx_byte       = 8'($urandom);
            expTx         = slotExp(nDone);
            txValid       = 1'b1;
            cfgValid      = 1'b1;
            tick($urandom_range(1, 7));
            closeWindows();
        end
        if (endIt) begin
            closeWindows();
            CS = 1'b1;
            tick(6);
            checkOutput("start_count", 128'(startSeen), 128'(expStarts));
            openWindows();
            tick(4);
        end else begin
            closeWindows();
        end
    endtask

    // Directed frames pinning the model, mid-frame reset, then random frames.
    initial begin
        int s0;
        int n;
        int kind;
        logic [7:0] c;

        vectors       = 0;
        miscompares   = 0;
        expStarts     = 0;
        startSeen     = 0;
        prevStart     = 1'b0;
        mErr          = 1'b0;
        mCmd          = 8'h00;
        mIsStart      = 0;
        mIsWrite      = 0;
        mIsRead       = 0;
        mAddr         = 0;
        txValid       = 0;
        cfgValid      = 0;
        expTx         = 8'h00;
        rst_n         = 1'b0;
        CS            = 1'b1;
        rx_byte       = 8'h00;
        rx_byte_ready = 1'b0;
        core_busy     = 1'b0;
        core_done     = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            mCfg[i] = 8'h00;
            mRes[i] = 8'h00;
        end
        for (int i = 0; i < 8; i++) begin
            txLog[i] = 8'h00;
        end

        tick(4);
        checkOutput("reset_tx", 128'(tx_byte), 128'(8'h00));
        checkOutput("reset_cfg", 128'(cfg_regs), 128'(0));
        checkOutput("reset_start", 128'(core_start), 128'(0));
        rst_n = 1'b1;
        tick(4);
        openWindows();
        tick(2);

        $display("[TB] burst write with wrap");
        frameQ = {8'h8E, 8'h11, 8'h22, 8'h33};
        applyStimulus(4, 0, 0, 1);
        checkOutput("wr_byte14", 128'(cfg_regs[119:112]), 128'(8'h11));
        checkOutput("wr_byte15", 128'(cfg_regs[127:120]), 128'(8'h22));
        checkOutput("wr_byte0", 128'(cfg_regs[7:0]), 128'(8'h33));
        checkOutput("wr_status", 128'(txLog[0]), 128'(8'h00));
        checkOutput("wr_tx1", 128'(txLog[1]), 128'(8'h00));

        $display("[TB] burst read of cfg and result banks");
        frameQ = {8'h0E, 8'h00, 8'h00, 8'h00};
        applyStimulus(4, 0, 0, 1);
        checkOutput("rd_cfg1", 128'(txLog[1]), 128'(8'h11));
        checkOutput("rd_cfg2", 128'(txLog[2]), 128'(8'h22));
        checkOutput("rd_cfg3", 128'(txLog[3]), 128'(8'h33));
        closeWindows();
        mRes[14] = 8'hE4;
        mRes[15] = 8'hF5;
        mRes[0]  = 8'h06;
        setEnv(1'b0, 1'b0, 0);
        frameQ = {8'h2E, 8'h00, 8'h00, 8'h00};
        applyStimulus(4, 0, 0, 1);
        checkOutput("rd_res1", 128'(txLog[1]), 128'(8'hE4));
        checkOutput("rd_res2", 128'(txLog[2]), 128'(8'hF5));
        checkOutput("rd_res3", 128'(txLog[3]), 128'(8'h06));

        $display("[TB] core start idle and busy");
        s0 = startSeen;
        frameQ = {8'h40};
        applyStimulus(1, 0, 0, 1);
        checkOutput("start_pulse", 128'(startSeen - s0), 128'(1));
        setEnv(1'b1, 1'b0, 0);
        s0 = startSeen;
        frameQ = {8'h40, 8'h55};
        applyStimulus(2, 0, 0, 1);
        checkOutput("start_busy", 128'(startSeen - s0), 128'(0));
        frameQ = {8'h0E, 8'h00};
        applyStimulus(2, 0, 0, 1);
        checkOutput("busy_err_status", 128'(txLog[0]), 128'(8'h81));
        frameQ = {8'h0E, 8'h00};
        applyStimulus(2, 0, 0, 1);
        checkOutput("err_cleared", 128'(txLog[0]), 128'(8'h80));
        setEnv(1'b0, 1'b0, 0);

        $display("[TB] illegal command");
        frameQ = {8'hA0, 8'hAA, 8'hAA};
        applyStimulus(3, 0, 0, 1);
        checkOutput("illegal_cfg0", 128'(cfg_regs[7:0]), 128'(8'h33));
        frameQ = {8'h0E, 8'h00};
        applyStimulus(2, 0, 0, 1);
        checkOutput("illegal_status", 128'(txLog[0]), 128'(8'h01));

        $display("[TB] CS abort mid byte");
        frameQ = {8'h83, 8'h5A, 8'hC3};
        applyStimulus(2, 1, 0, 1);
        checkOutput("abort_byte3", 128'(cfg_regs[31:24]), 128'(8'h5A));
        checkOutput("abort_byte4", 128'(cfg_regs[39:32]), 128'(8'h00));
        frameQ = {8'h03, 8'h00};
        applyStimulus(2, 0, 0, 1);
        checkOutput("abort_status", 128'(txLog[0]), 128'(8'h00));
        checkOutput("abort_readback", 128'(txLog[1]), 128'(8'h5A));

        $display("[TB] reset mid frame");
        frameQ = {8'h85, 8'h77};
        applyStimulus(2, 0, 0, 0);
        rx_byte_ready = 1'b0;
        rst_n = 1'b0;
        tick(1);
        checkOutput("midrst_tx", 128'(tx_byte), 128'(8'h00));
        checkOutput("midrst_cfg", 128'(cfg_regs), 128'(0));
        checkOutput("midrst_start", 128'(core_start), 128'(0));
        for (int i = 0; i < NREGS; i++) begin
            mCfg[i] = 8'h00;
        end
        mErr = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);
        openWindows();
        tick(2);
        frameQ = {8'h05, 8'h00};
        applyStimulus(2, 0, 1, 1);
        checkOutput("postrst_read", 128'(txLog[1]), 128'(8'h00));

        $display("[TB] random frames");
        for (int f = 0; f < 60; f++) begin
            setEnv(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            kind = $urandom_range(0, 4);
            case (kind)
                0:       c = 8'h80 | 8'($urandom_range(0, 15));
                1:       c = 8'($urandom_range(0, 1) << 5) | 8'($urandom_range(0, 15));
                2:       c = 8'h40 | 8'($urandom_range(0, 15));
                default: c = 8'($urandom);
            endcase
            frameQ.delete();
            frameQ.push_back(c);
            n = $urandom_range(0, 6);
            for (int k = 0; k < 6; k++) begin
                frameQ.push_back(8'($urandom));
            end
            applyStimulus(n, (n == 0) || ($urandom_range(0, 3) == 0), 0, 1);
        end

        closeWindows();
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
